branch_resolve_queue: RTL

//   In-order tracker for in-flight predicted branches between fetch and execute.

---
 rtl/branch_resolve_queue_if.sv | 39 +++
 rtl/branch_resolve_queue.sv | 131 +++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_queue_if
//  Description : Fetch/execute/predictor-facing signal bundle for the branch
//                resolve queue. The master modport is the environment side;
//                the slave modport is the queue itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_queue_if #(
    parameter int W_BRID = 2,
    parameter int W_PTR  = 2
);
    logic              push_i;
    logic              push_pred_i;
    logic [W_BRID-1:0] push_id_i;
    logic              full_o;
    logic              res_v_i;
    logic              res_taken_i;
    logic              upd_v_o;
    logic              upd_branch_o;
    logic [W_BRID-1:0] upd_id_o;
    logic              miss_o;
    logic              flush_o;
    logic [W_PTR:0]    count_o;
    logic              err_o;

    modport master (
        output push_i, push_pred_i, push_id_i, res_v_i, res_taken_i,
        input  full_o, upd_v_o, upd_branch_o, upd_id_o, miss_o, flush_o,
               count_o, err_o
    );

    modport slave (
        input  push_i, push_pred_i, push_id_i, res_v_i, res_taken_i,
        output full_o, upd_v_o, upd_branch_o, upd_id_o, miss_o, flush_o,
               count_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_queue
//  Description : In-order tracker for in-flight predicted branches. Fetch
//                pushes predictions, execute resolves the oldest one, and the
//                block emits a one-cycle-late predictor update. A mispredict
//                discards every tracked entry and holds fetch off for
//                FLUSH_CYC cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_queue #(
    parameter int W_BRID    = 2,
    parameter int DEPTH     = 4,
    parameter int W_PTR     = 2,
    parameter int FLUSH_CYC = 2
) (
    input  wire logic               clk,
    input  wire logic               reset,
    branch_resolve_queue_if.slave   bus
);

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

    localparam int               c_W_FCNT     = $clog2(FLUSH_CYC + 1);
    localparam logic [c_W_FCNT-1:0] c_FLUSH_LOAD = c_W_FCNT'(FLUSH_CYC - 1);
    localparam logic [c_W_FCNT-1:0] c_FCNT_ONE   = c_W_FCNT'(1);
    localparam logic [W_PTR:0]   c_DEPTH      = (W_PTR + 1)'(DEPTH);
    localparam logic [W_PTR:0]   c_CNT_ONE    = (W_PTR + 1)'(1);
    localparam logic [W_PTR-1:0] c_PTR_ONE    = W_PTR'(1);

    logic [0:0]          r_state;
    logic [W_PTR-1:0]    r_head;
    logic [W_PTR-1:0]    r_tail;
    logic [W_PTR:0]      r_count;
    logic [c_W_FCNT-1:0] r_fcnt;
    logic                r_upd_v;
    logic                r_upd_branch;
    logic [W_BRID-1:0]   r_upd_id;
    logic                r_miss;
    logic                r_err;

    logic                r_pred [DEPTH];
    logic [W_BRID-1:0]   r_id   [DEPTH];

    logic w_full;
    logic w_push;
    logic w_res_legal;
    logic w_mispredict;

    // Fetch stalls when storage is full or while recovering from a mispredict
    assign w_full       = (r_count == c_DEPTH) | (r_state == c_ST_FLUSH);
    assign w_push       = bus.push_i & ~w_full;
    assign w_res_legal  = bus.res_v_i & (r_state == c_ST_RUN) & (r_count != '0);
    assign w_mispredict = w_res_legal & (r_pred[r_head] != bus.res_taken_i);

    // Entry storage; a write on the mispredict cycle is harmless since the
    // pointers are cleared and the slot is treated as empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pred[r_tail] <= bus.push_pred_i;
            r_id[r_tail]   <= bus.push_id_i;
        end
    end

    // Pointers, occupancy, recovery FSM and registered predictor update
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_ST_RUN;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_fcnt       <= '0;
            r_upd_v      <= 1'b0;
            r_upd_branch <= 1'b0;
            r_upd_id     <= '0;
            r_miss       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_upd_v <= w_res_legal;
            r_miss  <= w_mispredict;
            if (w_res_legal) begin
                r_upd_branch <= bus.res_taken_i;
                r_upd_id     <= r_id[r_head];
            end
            if (bus.res_v_i && !w_res_legal) begin
                r_err <= 1'b1;
            end

            if (w_mispredict) begin
                // Everything in flight is on the wrong path, including a
                // push accepted this same cycle
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_state <= c_ST_FLUSH;
                r_fcnt  <= c_FLUSH_LOAD;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + c_PTR_ONE;
                end
                if (w_res_legal) begin
                    r_head <= r_head + c_PTR_ONE;
                end
                case ({w_push, w_res_legal})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
                if (r_state == c_ST_FLUSH) begin
                    if (r_fcnt == '0) begin
                        r_state <= c_ST_RUN;
                    end else begin
                        r_fcnt <= r_fcnt - c_FCNT_ONE;
                    end
                end
            end
        end
    end

    assign bus.full_o       = w_full;
    assign bus.upd_v_o      = r_upd_v;
    assign bus.upd_branch_o = r_upd_branch;
    assign bus.upd_id_o     = r_upd_id;
    assign bus.miss_o       = r_miss;
    assign bus.flush_o      = (r_state == c_ST_FLUSH);
    assign bus.count_o      = r_count;
    assign bus.err_o        = r_err;

endmodule
`default_nettype wire
